gmii2xgmii_packer: RTL and testbench



---
 rtl/xgmii_pkg.sv | 46 ++++
 rtl/gmii2xgmii_packer.sv | 125 ++++++++++++
 tb/tb_gmii2xgmii_packer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/xgmii_pkg.sv
// Shared XGMII lane encodings, word layout and lane helpers for the GMII->XGMII packer.
package xgmii_pkg;

  localparam int LANES  = 8;
  localparam int DATA_W = 64;
  localparam int WORD_W = 72;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERR   = 8'hFE;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DROP, ST_ABORT} state_e;

  typedef struct packed {
    logic [LANES-1:0]  ctrl;
    logic [DATA_W-1:0] data;
  } xword_t;

  // Lane 0 = ERR, lane 1 = TERM, rest idle: marks a truncated frame to the reader.
  localparam xword_t ABORT_WORD = '{ctrl: 8'hFF, data: 64'h070707070707FDFE};

  function automatic xword_t lane_insert(input xword_t w, input logic [2:0] lane,
                                         input logic [7:0] b, input logic c);
    xword_t r;
    r = w;
    for (int i = 0; i < LANES; i++) begin
      if (lane == 3'(i)) begin
        r.data[8*i +: 8] = b;
        r.ctrl[i]        = c;
      end
    end
    return r;
  endfunction

  function automatic xword_t term_insert(input xword_t w, input logic [2:0] k);
    xword_t r;
    r = w;
    for (int i = 0; i < LANES; i++) begin
      if (3'(i) == k)      r = lane_insert(r, 3'(i), XGMII_TERM, 1'b1);
      else if (3'(i) > k)  r = lane_insert(r, 3'(i), XGMII_IDLE, 1'b1);
    end
    return r;
  endfunction

endpackage

// File: rtl/gmii2xgmii_packer.sv
// Packs GMII bytes into 72-bit XGMII words; a word is strobed the cycle after its last byte.
// A word offered while fifo_full is high is lost: the frame is dropped and closed with an abort word.
module gmii2xgmii_packer
  import xgmii_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           gmii_rxd,
  input  logic                 gmii_rx_dv,
  input  logic                 gmii_rx_er,
  output logic [WORD_W-1:0]    fifo_din,
  output logic                 fifo_wr_en,
  input  logic                 fifo_full,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic                 busy
);

  state_e               state_q, state_d;
  logic [2:0]           lane_q, lane_d;
  xword_t               acc_q, acc_d;
  xword_t               out_q, out_d;
  logic                 pend_q, pend_d;
  logic                 skip_q, skip_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic   wr_fire, word_lost, enter_abort;
  xword_t cur_word;

  assign wr_fire     = pend_q & ~fifo_full;
  // The abort word simply waits for space; any other blocked word truncates the frame.
  assign word_lost   = pend_q & fifo_full & (state_q != ST_ABORT);
  assign enter_abort = (state_d == ST_ABORT) && (state_q != ST_ABORT);
  assign cur_word    = gmii_rx_er ? lane_insert(acc_q, lane_q, XGMII_ERR, 1'b1)
                                  : lane_insert(acc_q, lane_q, gmii_rxd, 1'b0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lane_q     <= '0;
      acc_q      <= '0;
      out_q      <= '0;
      pend_q     <= 1'b0;
      skip_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      acc_q      <= acc_d;
      out_q      <= out_d;
      pend_q     <= pend_d;
      skip_q     <= skip_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (word_lost) begin
      state_d = gmii_rx_dv ? ST_DROP : ST_ABORT;
    end else begin
      case (state_q)
        ST_IDLE:  if (gmii_rx_dv)  state_d = ST_DATA;
        ST_DATA:  if (!gmii_rx_dv) state_d = ST_IDLE;
        // A frame that began while the abort word waited is discarded without a second abort.
        ST_DROP:  if (!gmii_rx_dv) state_d = skip_q ? ST_IDLE : ST_ABORT;
        ST_ABORT: if (wr_fire)     state_d = gmii_rx_dv ? ST_DROP : ST_IDLE;
        default:                   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    lane_d     = lane_q;
    acc_d      = acc_q;
    out_d      = out_q;
    pend_d     = (state_q == ST_ABORT) && !wr_fire;
    skip_d     = skip_q;
    drop_cnt_d = drop_cnt_q;
    if (word_lost) begin
      lane_d = '0;
      skip_d = 1'b0;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    if (enter_abort) begin
      out_d  = ABORT_WORD;
      pend_d = 1'b1;
      lane_d = '0;
      skip_d = 1'b0;
    end else if (!word_lost) begin
      case (state_q)
        ST_IDLE: begin
          if (gmii_rx_dv) begin
            acc_d  = lane_insert(acc_q, 3'd0, XGMII_START, 1'b1);
            lane_d = 3'd1;
          end
        end
        ST_DATA: begin
          if (!gmii_rx_dv) begin
            out_d  = term_insert(acc_q, lane_q);
            pend_d = 1'b1;
            lane_d = '0;
          end else if (lane_q == 3'd7) begin
            out_d  = cur_word;
            pend_d = 1'b1;
            lane_d = '0;
          end else begin
            acc_d  = cur_word;
            lane_d = lane_q + 3'd1;
          end
        end
        ST_DROP:  if (!gmii_rx_dv) skip_d = 1'b0;
        ST_ABORT: if (wr_fire && gmii_rx_dv) skip_d = 1'b1;
        default: ;
      endcase
    end
  end

  assign fifo_din   = out_q;
  assign fifo_wr_en = wr_fire;
  assign drop_cnt   = drop_cnt_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gmii2xgmii_packer.sv
// Directed bench for gmii2xgmii_packer: frames are driven byte by byte and FIFO writes are captured and compared.
module tb_gmii2xgmii_packer;

  logic        clk;
  logic        rst;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [71:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic [15:0] drop_cnt;
  logic        busy;

  gmii2xgmii_packer #(.CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .gmii_rxd   (gmii_rxd),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rx_er (gmii_rx_er),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .fifo_full  (fifo_full),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  localparam logic [71:0] W_FIRST = {8'h01, 64'hD5555555555555FB};
  localparam logic [71:0] W_TERM0 = {8'hFF, 64'h07070707070707FD};
  localparam logic [71:0] W_ABORT = {8'hFF, 64'h070707070707FDFE};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int viol    = 0;
  logic [71:0] wr_q[$];
  int          wr_cyc[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wr_q.push_back(fifo_din);
      wr_cyc.push_back(cyc);
      if (fifo_full) viol++;
    end
  end

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input int i);
    if (i < 7)  return 8'h55;
    if (i == 7) return 8'hD5;
    return 8'(i - 8);
  endfunction

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(posedge clk);
    #1;
    gmii_rx_dv = dv;
    gmii_rxd   = d;
    gmii_rx_er = er;
  endtask

  task automatic send_frame(input int len, input int er_idx, input int fs_idx,
                            input int fc_idx, input int gap, output int start_cyc);
    start_cyc = 0;
    for (int i = 0; i < len; i++) begin
      drive(1'b1, frame_byte(i), i == er_idx);
      if (i == 0)      start_cyc = cyc;
      if (i == fs_idx) fifo_full = 1'b1;
      if (i == fc_idx) fifo_full = 1'b0;
    end
    for (int g = 0; g < gap; g++) drive(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int c2;
    rst        = 1'b0;
    gmii_rxd   = 8'h00;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    fifo_full  = 1'b0;
    #2 rst = 1'b1;
    #2;
    check_eq("rst_wr_en", 72'(fifo_wr_en), 72'd0);
    check_eq("rst_din",   fifo_din, 72'd0);
    check_eq("rst_drop",  72'(drop_cnt), 72'd0);
    check_eq("rst_busy",  72'(busy), 72'd0);
    @(posedge clk); #1 rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);

    // 64-byte frame, no backpressure
    wr_q.delete(); wr_cyc.delete();
    send_frame(64, -1, -1, -1, 3, c);
    check_eq("f64_count",   72'(wr_q.size()), 72'd9);
    check_eq("f64_w0",      wr_q[0], W_FIRST);
    check_eq("f64_w1",      wr_q[1], {8'h00, 64'h0706050403020100});
    check_eq("f64_w7",      wr_q[7], {8'h00, 64'h3736353433323130});
    check_eq("f64_term",    wr_q[8], W_TERM0);
    check_eq("f64_w0_cyc",  72'(wr_cyc[0]), 72'(c + 8));
    for (int i = 1; i < 8; i++)
      check_eq($sformatf("f64_w%0d_gap", i), 72'(wr_cyc[i] - wr_cyc[i-1]), 72'd8);
    check_eq("f64_term_cyc", 72'(wr_cyc[8]), 72'(c + 65));
    check_eq("f64_busy_end", 72'(busy), 72'd0);

    // rx_er on byte 20
    wr_q.delete(); wr_cyc.delete();
    send_frame(64, 20, -1, -1, 3, c);
    check_eq("er_count", 72'(wr_q.size()), 72'd9);
    check_eq("er_w2",    wr_q[2], {8'h10, 64'h0F0E0DFE0B0A0908});
    check_eq("er_w3",    wr_q[3], {8'h00, 64'h1716151413121110});
    check_eq("er_term",  wr_q[8], W_TERM0);

    // back-to-back frames with a one-cycle gap
    wr_q.delete(); wr_cyc.delete();
    send_frame(16, -1, -1, -1, 1, c);
    send_frame(16, -1, -1, -1, 3, c2);
    check_eq("b2b_count",   72'(wr_q.size()), 72'd6);
    check_eq("b2b_term1",   wr_q[2], W_TERM0);
    check_eq("b2b_first2",  wr_q[3], W_FIRST);
    check_eq("b2b_first2_cyc", 72'(wr_cyc[3]), 72'(c2 + 8));
    check_eq("b2b_term2",   wr_q[5], W_TERM0);

    // full during word 3's write cycle: frame dropped, abort held until space
    wr_q.delete(); wr_cyc.delete();
    send_frame(64, -1, 32, -1, 3, c);
    check_eq("drop_count_held", 72'(wr_q.size()), 72'd3);
    check_eq("drop_cnt_1",      72'(drop_cnt), 72'd1);
    check_eq("drop_busy_abort", 72'(busy), 72'd1);
    send_frame(64, -1, -1, 10, 3, c);
    check_eq("abort_count",  72'(wr_q.size()), 72'd4);
    check_eq("abort_word",   wr_q[3], W_ABORT);
    check_eq("abort_cyc",    72'(wr_cyc[3]), 72'(c + 10));
    check_eq("abort_drop_cnt", 72'(drop_cnt), 72'd1);
    check_eq("abort_idle",   72'(busy), 72'd0);

    // asynchronous reset while a word is being strobed
    wr_q.delete(); wr_cyc.delete();
    for (int i = 0; i < 9; i++) drive(1'b1, frame_byte(i), 1'b0);
    #1;
    check_eq("prerst_wr_en", 72'(fifo_wr_en), 72'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst_wr_en", 72'(fifo_wr_en), 72'd0);
    check_eq("midrst_din",   fifo_din, 72'd0);
    check_eq("midrst_drop",  72'(drop_cnt), 72'd0);
    check_eq("midrst_busy",  72'(busy), 72'd0);
    gmii_rx_dv = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    check_eq("midrst_lost", 72'(wr_q.size()), 72'd0);

    // 61-byte frame after reset: partial last word
    wr_q.delete(); wr_cyc.delete();
    send_frame(61, -1, -1, -1, 3, c);
    check_eq("f61_count",    72'(wr_q.size()), 72'd8);
    check_eq("f61_w0",       wr_q[0], W_FIRST);
    check_eq("f61_last",     wr_q[7], {8'hE0, 64'h0707FD3433323130});
    check_eq("f61_last_cyc", 72'(wr_cyc[7]), 72'(c + 62));

    check_eq("no_wr_while_full", 72'(viol), 72'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
